// File: rtl/elevator_pkg.sv
// Shared constants and state encoding for the elevator motion controller.
// No ports: constants for door/motion levels, travel direction codes,
// FSM state type and the floor count.
package elevator_pkg;

    localparam int NUM_FLOORS = 7;

    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;
    localparam logic MOVE  = 1'b1;
    localparam logic HOLD  = 1'b0;
    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OPEN    = 2'd1,
        S_CLOSING = 2'd2,
        S_MOVING  = 2'd3
    } state_t;

endpackage

// File: rtl/request_summary.sv
// Combinational summary of the latched requests relative to one floor.
// Ports:
//   floor_button  in  [13:0] hall calls, bit 2*(f-1)=UP at f, bit 2*(f-1)+1=DOWN at f
//   car_button    in  [7:1]  car floor-select buttons
//   sel_floor     in  [2:0]  floor being evaluated (1..7)
//   at_floor      out        any request at sel_floor
//   at_car        out        car button for sel_floor
//   at_up/at_down out        hall UP / DOWN call at sel_floor
//   above/below   out        any request strictly above / below sel_floor
module request_summary
    import elevator_pkg::*;
(
    input  logic [13:0]           floor_button,
    input  logic [NUM_FLOORS:1]   car_button,
    input  logic [2:0]            sel_floor,
    output logic                  at_floor,
    output logic                  at_car,
    output logic                  at_up,
    output logic                  at_down,
    output logic                  above,
    output logic                  below
);

    // DOWN at the bottom floor and UP at the top floor cannot exist.
    localparam logic [13:0] HALL_MASK = 14'b10_1111_1111_1101;

    logic [13:0]         hall;
    logic [NUM_FLOORS:1] up_call;
    logic [NUM_FLOORS:1] down_call;
    logic [NUM_FLOORS:1] req;

    assign hall = floor_button & HALL_MASK;

    for (genvar g = 1; g <= NUM_FLOORS; g++) begin : g_req
        assign up_call[g]   = hall[2*g-2];
        assign down_call[g] = hall[2*g-1];
    end

    assign req = car_button | up_call | down_call;

    always_comb begin
        at_floor = OFF;
        at_car   = OFF;
        at_up    = OFF;
        at_down  = OFF;
        above    = OFF;
        below    = OFF;
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (f > int'(sel_floor)) above = above | req[f];
            if (f < int'(sel_floor)) below = below | req[f];
            if (f == int'(sel_floor)) begin
                at_floor = req[f];
                at_car   = car_button[f];
                at_up    = up_call[f];
                at_down  = down_call[f];
            end
        end
    end

endmodule

// File: rtl/elevator_motion_controller.sv
// Collective-scheduling motion controller for a 7-floor car.
// Ports:
//   clk              in        clock, posedge
//   reset            in        synchronous, active-high
//   floorButton      in [13:0] latched hall calls
//   internalButton   in [9:1]  car buttons: 1..7 floor select, 8 door-open, 9 door-close
//   currentFloor     out [2:0] present floor 1..7
//   currentDirection out [1:0] 01 UP, 10 DOWN, 00 none
//   doorState        out       1 OPEN, 0 CLOSE
//   move             out       1 MOVE, 0 HOLD
//
// state     | meaning
// S_IDLE    | parked, door closed, waiting for any request
// S_OPEN    | door open, dwell counter running
// S_CLOSING | door closed one cycle so the latch settles before deciding
// S_MOVING  | travelling, counter times one floor
module elevator_motion_controller
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES  = 8,
    parameter int FLOOR_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] floorButton,
    input  logic [9:1]  internalButton,
    output logic [2:0]  currentFloor,
    output logic [1:0]  currentDirection,
    output logic        doorState,
    output logic        move
);

    localparam int CNT_MAX = (DOOR_CYCLES > FLOOR_CYCLES) ? DOOR_CYCLES : FLOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic [2:0]       floor_next, step_floor, eval_floor;
    logic [1:0]       dir_next;
    logic             door_next, move_next;
    logic             at_floor, at_car, at_up, at_down, above, below;
    logic             ahead, opposite;

    // Floor reached when the current travel leg expires, saturating at the ends.
    always_comb begin
        step_floor = currentFloor;
        if (currentDirection == DIR_UP && currentFloor != 3'(NUM_FLOORS))
            step_floor = currentFloor + 3'd1;
        else if (currentDirection == DIR_DOWN && currentFloor != 3'd1)
            step_floor = currentFloor - 3'd1;
    end

    // While moving, the only decision is the stop test at the arrival floor,
    // so one summary instance serves every state.
    assign eval_floor = (state == S_MOVING) ? step_floor : currentFloor;

    request_summary u_summary (
        .floor_button (floorButton),
        .car_button   (internalButton[NUM_FLOORS:1]),
        .sel_floor    (eval_floor),
        .at_floor     (at_floor),
        .at_car       (at_car),
        .at_up        (at_up),
        .at_down      (at_down),
        .above        (above),
        .below        (below)
    );

    assign ahead    = (currentDirection == DIR_UP) ? above : below;
    assign opposite = (currentDirection == DIR_UP) ? at_down : at_up;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            counter          <= '0;
            currentFloor     <= 3'd1;
            currentDirection <= DIR_NONE;
            doorState        <= CLOSE;
            move             <= HOLD;
        end else begin
            state            <= state_next;
            counter          <= counter_next;
            currentFloor     <= floor_next;
            currentDirection <= dir_next;
            doorState        <= door_next;
            move             <= move_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = '0;
        floor_next   = currentFloor;
        dir_next     = currentDirection;
        case (state)
            S_IDLE: begin
                if (internalButton[8] || at_floor) begin
                    state_next = S_OPEN;
                    if (at_up)        dir_next = DIR_UP;
                    else if (at_down) dir_next = DIR_DOWN;
                end else if (above) begin
                    state_next = S_MOVING;
                    dir_next   = DIR_UP;
                end else if (below) begin
                    state_next = S_MOVING;
                    dir_next   = DIR_DOWN;
                end else begin
                    dir_next = DIR_NONE;
                end
            end
            S_OPEN: begin
                if (internalButton[8])
                    counter_next = '0;
                else if (internalButton[9] || counter == DOOR_LAST)
                    state_next = S_CLOSING;
                else
                    counter_next = counter + 1'b1;
            end
            S_CLOSING: begin
                if (currentDirection == DIR_UP && above) begin
                    state_next = S_MOVING;
                end else if (currentDirection == DIR_DOWN && below) begin
                    state_next = S_MOVING;
                end else if (currentDirection == DIR_UP && at_down) begin
                    state_next = S_OPEN;
                    dir_next   = DIR_DOWN;
                end else if (currentDirection == DIR_DOWN && at_up) begin
                    state_next = S_OPEN;
                    dir_next   = DIR_UP;
                end else if (above) begin
                    state_next = S_MOVING;
                    dir_next   = DIR_UP;
                end else if (below) begin
                    state_next = S_MOVING;
                    dir_next   = DIR_DOWN;
                end else begin
                    state_next = S_IDLE;
                    dir_next   = DIR_NONE;
                end
            end
            S_MOVING: begin
                if (counter != FLOOR_LAST) begin
                    counter_next = counter + 1'b1;
                end else begin
                    floor_next = step_floor;
                    if (at_car || (currentDirection == DIR_UP && at_up)
                               || (currentDirection == DIR_DOWN && at_down)) begin
                        state_next = S_OPEN;
                    end else if (!ahead) begin
                        if (opposite) begin
                            state_next = S_OPEN;
                            dir_next   = (currentDirection == DIR_UP) ? DIR_DOWN : DIR_UP;
                        end else begin
                            // Nothing here or ahead; IDLE picks up any request
                            // left behind on its next decision.
                            state_next = S_IDLE;
                            dir_next   = DIR_NONE;
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        door_next = (state_next == S_OPEN)   ? OPEN : CLOSE;
        move_next = (state_next == S_MOVING) ? MOVE : HOLD;
    end

endmodule

// File: tb/tb_elevator_motion_controller.sv
module tb_elevator_motion_controller;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DOWN = 2'b10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] floorButton = '0;
    logic [9:1]  internalButton = '0;
    logic [2:0]  currentFloor;
    logic [1:0]  currentDirection;
    logic        doorState;
    logic        move;

    int vectors = 0;
    int miscompares = 0;

    elevator_motion_controller #(
        .DOOR_CYCLES  (4),
        .FLOOR_CYCLES (3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .floorButton      (floorButton),
        .internalButton   (internalButton),
        .currentFloor     (currentFloor),
        .currentDirection (currentDirection),
        .doorState        (doorState),
        .move             (move)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and act as the button latch:
    // an open door clears the car call and the hall call being served.
    task automatic tick();
        int f;
        @(negedge clk);
        if (doorState === 1'b1) begin
            f = int'(currentFloor);
            if (f >= 1 && f <= 7) begin
                internalButton[f] = 1'b0;
                if (currentDirection != DOWN) floorButton[2*f-2] = 1'b0;
                if (currentDirection != UP)   floorButton[2*f-1] = 1'b0;
            end
        end
    endtask

    task automatic wait_door_open(input string tag);
        int n = 0;
        while (doorState !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        vectors++;
        if (doorState !== 1'b1) begin
            miscompares++;
            $display("FAIL %s door_open_timeout door=%b required 1", tag, doorState);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(doorState === 1'b0 && move === 1'b0 && currentDirection === NONE) && n < 60) begin
            tick();
            n++;
        end
        vectors++;
        if (!(doorState === 1'b0 && move === 1'b0 && currentDirection === NONE)) begin
            miscompares++;
            $display("FAIL %s idle_timeout door=%b move=%b dir=%b required 0 0 00",
                     tag, doorState, move, currentDirection);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if (currentFloor !== 3'd1 || currentDirection !== NONE || doorState !== 1'b0 || move !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d floor=%0d dir=%b door=%b move=%b required 1 00 0 0",
                         k, currentFloor, currentDirection, doorState, move);
            end
        end
    endtask

    task automatic test_ignored_bits();
        floorButton = 14'h1002;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (currentFloor !== 3'd1 || doorState !== 1'b0 || move !== 1'b0) begin
                miscompares++;
                $display("FAIL ignored_bits cyc=%0d floor=%0d door=%b move=%b required 1 0 0",
                         k, currentFloor, doorState, move);
            end
        end
        floorButton = '0;
        tick();
    endtask

    task automatic test_single_trip();
        logic [2:0] ef;
        logic [1:0] ed;
        logic       em, eo;
        internalButton[5] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            ef = (k <= 12) ? 3'(1 + (k - 1) / 3) : 3'd5;
            em = (k <= 12);
            eo = (k >= 13 && k <= 16);
            ed = (k <= 17) ? UP : NONE;
            vectors++;
            if (currentFloor !== ef) begin
                miscompares++;
                $display("FAIL trip_floor cyc=%0d got=%0d required=%0d", k, currentFloor, ef);
            end
            vectors++;
            if (move !== em) begin
                miscompares++;
                $display("FAIL trip_move cyc=%0d got=%b required=%b", k, move, em);
            end
            vectors++;
            if (doorState !== eo) begin
                miscompares++;
                $display("FAIL trip_door cyc=%0d got=%b required=%b", k, doorState, eo);
            end
            vectors++;
            if (currentDirection !== ed) begin
                miscompares++;
                $display("FAIL trip_dir cyc=%0d got=%b required=%b", k, currentDirection, ed);
            end
        end
    endtask

    task automatic test_collective_up();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        floorButton[4]    = 1'b1;
        internalButton[6] = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            vectors++;
            if (currentDirection !== ((k <= 25) ? UP : NONE)) begin
                miscompares++;
                $display("FAIL collective_dir cyc=%0d got=%b required=%b",
                         k, currentDirection, (k <= 25) ? UP : NONE);
            end
            if (k == 7 || k == 21) begin
                vectors++;
                if (doorState !== 1'b1 || move !== 1'b0 || currentFloor !== ((k == 7) ? 3'd3 : 3'd6)) begin
                    miscompares++;
                    $display("FAIL collective_stop cyc=%0d floor=%0d door=%b move=%b required floor %0d door 1 move 0",
                             k, currentFloor, doorState, move, (k == 7) ? 3 : 6);
                end
            end
            if (k == 12) begin
                vectors++;
                if (move !== 1'b1 || currentFloor !== 3'd3) begin
                    miscompares++;
                    $display("FAIL collective_resume floor=%0d move=%b required 3 1", currentFloor, move);
                end
            end
        end
    endtask

    task automatic test_reverse_at_top_call();
        internalButton[4] = 1'b1;
        wait_door_open("to_floor4");
        vectors++;
        if (currentFloor !== 3'd4) begin
            miscompares++;
            $display("FAIL to_floor4 floor=%0d required 4", currentFloor);
        end
        wait_idle("idle_at_4");
        floorButton[11] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            vectors++;
            if (currentFloor !== ((k < 4) ? 3'd4 : (k < 7) ? 3'd5 : 3'd6) ||
                currentDirection !== ((k < 7) ? UP : DOWN) ||
                move !== (k < 7) || doorState !== (k == 7)) begin
                miscompares++;
                $display("FAIL reverse cyc=%0d floor=%0d dir=%b move=%b door=%b",
                         k, currentFloor, currentDirection, move, doorState);
            end
        end
        wait_idle("reverse_idle");
        vectors++;
        if (currentFloor !== 3'd6) begin
            miscompares++;
            $display("FAIL reverse_park floor=%0d required 6", currentFloor);
        end
    endtask

    task automatic test_door_buttons();
        int opened;
        internalButton[2] = 1'b1;
        wait_door_open("to_floor2");
        vectors++;
        if (currentFloor !== 3'd2 || currentDirection !== DOWN) begin
            miscompares++;
            $display("FAIL to_floor2 floor=%0d dir=%b required 2 10", currentFloor, currentDirection);
        end
        opened = 1;
        tick();
        if (doorState === 1'b1) opened++;
        internalButton[8] = 1'b1;
        tick();
        internalButton[8] = 1'b0;
        for (int i = 0; i < 20 && doorState === 1'b1; i++) begin
            opened++;
            tick();
        end
        vectors++;
        if (opened != 6) begin
            miscompares++;
            $display("FAIL door_extend open_cycles=%0d required 6", opened);
        end
        wait_idle("extend_idle");
        internalButton[8] = 1'b1;
        tick();
        internalButton[8] = 1'b0;
        vectors++;
        if (doorState !== 1'b1) begin
            miscompares++;
            $display("FAIL door_open_btn door=%b required 1", doorState);
        end
        internalButton[9] = 1'b1;
        tick();
        internalButton[9] = 1'b0;
        vectors++;
        if (doorState !== 1'b0 || move !== 1'b0) begin
            miscompares++;
            $display("FAIL door_close_btn door=%b move=%b required 0 0", doorState, move);
        end
        wait_idle("close_idle");
    endtask

    task automatic test_reset_mid_travel();
        internalButton[5] = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        vectors++;
        if (currentFloor !== 3'd3 || move !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_travel floor=%0d move=%b required 3 1", currentFloor, move);
        end
        reset = 1'b1;
        internalButton = '0;
        tick();
        vectors++;
        if (currentFloor !== 3'd1 || move !== 1'b0 || doorState !== 1'b0 || currentDirection !== NONE) begin
            miscompares++;
            $display("FAIL reset_mid floor=%0d move=%b door=%b dir=%b required 1 0 0 00",
                     currentFloor, move, doorState, currentDirection);
        end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (currentFloor !== 3'd1 || move !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_after floor=%0d move=%b required 1 0", currentFloor, move);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ignored_bits();
        test_single_trip();
        test_collective_up();
        test_reverse_at_top_call();
        test_door_buttons();
        test_reset_mid_travel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
